// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: requester and memory-side signals of memory_arbiter
//   fetch  : if_req, if_addr -> if_rdata, if_ack
//   data   : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ack
//   loader : ld_req, ld_addr, ld_wdata -> ld_ack
//   memory : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   status : grant (00 none, 01 fetch, 10 data, 11 loader), busy
//   slave modport = arbiter side, master modport = requesters/memory side
interface memory_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_ack;
    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic                  ld_ack;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [1:0]            grant;
    logic                  busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               ld_req, ld_addr, ld_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, ld_ack,
               mem_en, mem_we, mem_addr, mem_wdata, grant, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               ld_req, ld_addr, ld_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, ld_ack,
               mem_en, mem_we, mem_addr, mem_wdata, grant, busy
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between fetch, data and loader requesters
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : memory_arbiter_if.slave carrying all requester, memory and status signals
//   MEM_LATENCY (1..7): cycles from the mem_en cycle to valid mem_rdata
module memory_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input logic             clk,
    input logic             reset,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       last_cpu;
    logic       pick_dm;

    // last_cpu: 1 = data was the last cpu-side grant, so fetch wins the next tie
    assign pick_dm = bus.dm_req && (!bus.if_req || !last_cpu);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            last_cpu      <= 1'b0;
            bus.grant     <= 2'b00;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.dm_ack    <= 1'b0;
            bus.ld_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.ld_req || bus.dm_req || bus.if_req) begin
                    state      <= ISSUE;
                    bus.busy   <= 1'b1;
                    bus.mem_en <= 1'b1;
                    if (bus.ld_req) begin
                        bus.grant     <= 2'b11;
                        bus.mem_addr  <= bus.ld_addr;
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= bus.ld_wdata;
                    end else if (pick_dm) begin
                        bus.grant     <= 2'b10;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_wdata <= bus.dm_wdata;
                        last_cpu      <= 1'b1;
                    end else begin
                        // fetch carries no write data; latch zero
                        bus.grant     <= 2'b01;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wdata <= '0;
                        last_cpu      <= 1'b0;
                    end
                end
                ISSUE: begin
                    bus.mem_en <= 1'b0;
                    cnt        <= MEM_LATENCY[2:0];
                    state      <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // mem_rdata is valid only in the last wait cycle
                    if (cnt == 3'd1) begin
                        state      <= ACK;
                        bus.if_ack <= bus.grant == 2'b01;
                        bus.dm_ack <= bus.grant == 2'b10;
                        bus.ld_ack <= bus.grant == 2'b11;
                        if (bus.grant == 2'b01)
                            bus.if_rdata <= bus.mem_rdata;
                        if (bus.grant == 2'b10 && !bus.mem_we)
                            bus.dm_rdata <= bus.mem_rdata;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    bus.grant  <= 2'b00;
                    bus.busy   <= 1'b0;
                    bus.if_ack <= 1'b0;
                    bus.dm_ack <= 1'b0;
                    bus.ld_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the CPU's single-port 16-bit memory between three requesters: instruction fetch (program counter / instruction register path), data access (load/store issued by the control logic via MW/MD), and an external program loader. It sits between the CPU controller and the memory. It serialises accesses through a four-state FSM, applies the memory's fixed read latency, and returns read data with a one-cycle acknowledge to the winning requester.

## Interface
- DATA_WIDTH, 16, memory word and bus width
- ADDR_WIDTH, 16, memory address width
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- if_req  in  1  fetch request, level, read-only
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched instruction, registered
- if_ack  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, level
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_rdata  out  DATA_WIDTH  load data, registered
- dm_ack  out  1  one-cycle completion pulse for data
- ld_req  in  1  loader write request, level, write-only
- ld_addr  in  ADDR_WIDTH  loader address
- ld_wdata  in  DATA_WIDTH  loader write data
- ld_ack  out  1  one-cycle completion pulse for loader
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- grant  out  2  current owner: 00 none, 01 fetch, 10 data, 11 loader
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any request is high, select a winner, latch its addr, we and wdata into mem_addr, mem_we and mem_wdata, set grant, and go to ISSUE. Otherwise stay in IDLE with grant = 00.
- Winner priority: loader highest. Between dm and if, a lone request wins. When both are pending, they alternate using a last_cpu bit: the one not granted last wins. last_cpu updates only on dm/if grants.
- ISSUE: mem_en = 1 for exactly one cycle. mem_we = 1 in this cycle only for stores and loader writes. Load the wait counter with MEM_LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter equals 1, capture mem_rdata into the owner's rdata register (reads only) and go to ACK.
- ACK: the owner's ack = 1 for one cycle, then go to IDLE. grant is held through ACK.
- Requesters hold req, addr and wdata stable until their ack. To issue back-to-back requests, keep req high through the ack cycle; the arbiter re-arbitrates in IDLE.
- No preemption: a request arriving mid-transaction waits. If req drops mid-transaction, the access still completes and ack still pulses.
- Writes never modify any rdata register. if_rdata and dm_rdata hold their value until the next read by that requester.
- mem_addr, mem_wdata and mem_we hold their latched values until the next grant. mem_we is meaningful only with mem_en.

## Timing
- Reset values: state IDLE, grant 00, busy 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, all ack 0, if_rdata 0, dm_rdata 0, counter 0, last_cpu = fetch (data wins the first tie).
- Reset asserted mid-transaction aborts it immediately. No ack is issued and outputs return to reset values asynchronously.
- Request sampled high in IDLE at edge N: ISSUE is cycle N+1, WAIT spans cycles N+2 .. N+1+MEM_LATENCY, ACK is cycle N+2+MEM_LATENCY.
- With MEM_LATENCY = 1 an access occupies 4 cycles including IDLE. The maximum sustained rate is one access per 4 cycles.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan
- Reset, then if_req = 1, if_addr = 0x0010, memory returns 0xA5A5 with MEM_LATENCY = 1 -> mem_en high in cycle 1 with mem_addr 0x0010, if_ack in cycle 3, if_rdata = 0xA5A5, grant 01 for cycles 1-3.
- Store: dm_we = 1, dm_addr = 0x0200, dm_wdata = 0x1234 -> one cycle with mem_en = mem_we = 1, mem_wdata = 0x1234, then dm_ack; dm_rdata remains 0.
- if_req and dm_req held high for 4 accesses -> grants in order data, fetch, data, fetch; each ack arrives 4 cycles apart.
- ld_req raised during a fetch WAIT while dm_req is also pending -> the fetch completes, then the loader is granted (grant 11), then data.
- MEM_LATENCY = 3 read of 0xBEEF -> ack 5 cycles after the ISSUE-to-IDLE sampling edge, rdata = 0xBEEF, and mem_rdata garbage in earlier WAIT cycles is not captured.
- reset pulled low during WAIT -> no ack, grant 00, busy 0 asynchronously; after release, a pending dm_req is served normally.
